writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile_pkg.sv | 18 +
 rtl/writeback_regfile_wb_select.sv | 29 ++
 rtl/writeback_regfile.sv | 65 ++++++
 tb/tb_writeback_regfile.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared constants and the writeback request type for the writeback register file.
// No logic here: widths, the RegWrite encodings and the link register index.
package writeback_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;
  localparam logic [1:0]        RW_NONE  = 2'b00;
  localparam logic [1:0]        RW_WRITE = 2'b01;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_t;

endpackage

// File: rtl/writeback_regfile_wb_select.sv
// Chooses writeback data, destination and enable from the MEM/WB controls.
// Purely combinational, zero latency; no flow control.
module wb_select
  import writeback_regfile_pkg::*;
(
  input  logic              MemToReg,
  input  logic [1:0]        RegWrite,
  input  logic              Jal,
  input  logic [ADDR_W-1:0] RegWriteAddress,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] PCAdderOut,
  input  logic [DATA_W-1:0] MemReadData,
  output wb_t               wb
);

  always_comb begin
    wb = '0;
    if (Jal) begin
      wb.data = PCAdderOut;
      wb.addr = REG_RA;
    end else begin
      wb.data = MemToReg ? MemReadData : ALUResult;
      wb.addr = RegWriteAddress;
    end
    // Reserved RegWrite codes never write; R0 is hardwired so writes to it vanish.
    wb.en = (Jal || (RegWrite == RW_WRITE)) && (wb.addr != '0);
  end

endmodule

// File: rtl/writeback_regfile.sv
// 32x32 register file with writeback selection and same-cycle write-to-read bypass.
// Writes land one clk edge later; reads and WB* forwarding outputs are combinational; no backpressure.
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              MemToReg,
  input  logic [1:0]        RegWrite,
  input  logic              Jal,
  input  logic [ADDR_W-1:0] RegWriteAddress,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] PCAdderOut,
  input  logic [DATA_W-1:0] MemReadData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              WBWriteEnable,
  output logic [ADDR_W-1:0] WBWriteAddress,
  output logic [DATA_W-1:0] WBWriteData
);

  wb_t sel;
  logic [DATA_W-1:0] regs [1:31];

  wb_select u_wb_select (
    .MemToReg        (MemToReg),
    .RegWrite        (RegWrite),
    .Jal             (Jal),
    .RegWriteAddress (RegWriteAddress),
    .ALUResult       (ALUResult),
    .PCAdderOut      (PCAdderOut),
    .MemReadData     (MemReadData),
    .wb              (sel)
  );

  assign WBWriteEnable  = sel.en & ~reset;
  assign WBWriteAddress = sel.addr;
  assign WBWriteData    = sel.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (WBWriteEnable) begin
      regs[WBWriteAddress] <= WBWriteData;
    end
  end

  // R0 has no storage; any in-flight write to the addressed register wins over storage.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    v = '0;
    if (reset || ra == '0) v = '0;
    else if (WBWriteEnable && WBWriteAddress == ra) v = WBWriteData;
    else v = regs[ra];
    return v;
  endfunction

  always_comb begin
    ReadData1 = read_port(ReadRegister1);
    ReadData2 = read_port(ReadRegister2);
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against an array-based model, plus directed literal checks.
module tb_writeback_regfile;

  logic        clk;
  logic        reset;
  logic        MemToReg;
  logic [1:0]  RegWrite;
  logic        Jal;
  logic [4:0]  RegWriteAddress;
  logic [31:0] ALUResult, PCAdderOut, MemReadData;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2;
  logic        WBWriteEnable;
  logic [4:0]  WBWriteAddress;
  logic [31:0] WBWriteData;

  int checks = 0;
  int failures = 0;
  logic [31:0] mreg [32];

  writeback_regfile dut (
    .clk             (clk),
    .reset           (reset),
    .MemToReg        (MemToReg),
    .RegWrite        (RegWrite),
    .Jal             (Jal),
    .RegWriteAddress (RegWriteAddress),
    .ALUResult       (ALUResult),
    .PCAdderOut      (PCAdderOut),
    .MemReadData     (MemReadData),
    .ReadRegister1   (ReadRegister1),
    .ReadRegister2   (ReadRegister2),
    .ReadData1       (ReadData1),
    .ReadData2       (ReadData2),
    .WBWriteEnable   (WBWriteEnable),
    .WBWriteAddress  (WBWriteAddress),
    .WBWriteData     (WBWriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the writeback stage must do this cycle, straight from the rules.
  function automatic logic m_we();
    logic [4:0] d;
    d = Jal ? 5'd31 : RegWriteAddress;
    return !reset && (Jal || RegWrite == 2'b01) && d != 5'd0;
  endfunction

  function automatic logic [4:0] m_dest();
    return Jal ? 5'd31 : RegWriteAddress;
  endfunction

  function automatic logic [31:0] m_data();
    if (Jal) return PCAdderOut;
    if (MemToReg) return MemReadData;
    return ALUResult;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    if (reset || ra == 5'd0) return 32'h0;
    if (m_we() && m_dest() == ra) return m_data();
    return mreg[ra];
  endfunction

  initial for (int i = 0; i < 32; i++) mreg[i] = 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    end else if (m_we()) begin
      mreg[m_dest()] = m_data();
    end
  end

  // Continuous compare against the model on every falling edge.
  always @(negedge clk) begin
    chk("rd1", ReadData1, m_read(ReadRegister1));
    chk("rd2", ReadData2, m_read(ReadRegister2));
    chk("wb_en", {31'h0, WBWriteEnable}, {31'h0, m_we()});
    if (m_we()) begin
      chk("wb_addr", {27'h0, WBWriteAddress}, {27'h0, m_dest()});
      chk("wb_data", WBWriteData, m_data());
    end
  end

  task automatic idle();
    MemToReg = 1'b0; RegWrite = 2'b00; Jal = 1'b0; RegWriteAddress = 5'd0;
    ALUResult = 32'h0; PCAdderOut = 32'h0; MemReadData = 32'h0;
  endtask

  task automatic wr(input logic [1:0] rw, input logic m2r, input logic j,
                    input logic [4:0] a, input logic [31:0] alu,
                    input logic [31:0] pc, input logic [31:0] mem);
    RegWrite = rw; MemToReg = m2r; Jal = j; RegWriteAddress = a;
    ALUResult = alu; PCAdderOut = pc; MemReadData = mem;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    ReadRegister1 = 5'd8; ReadRegister2 = 5'd0;
    wr(2'b01, 1'b0, 1'b0, 5'd8, 32'h5, 32'h0, 32'h0);
    at_neg();
    chk("lit_reset_en", {31'h0, WBWriteEnable}, 32'h0);
    chk("lit_reset_rd", ReadData1, 32'h0);
    next(); next();
    reset = 1'b0;

    // Basic ALU write to R8.
    wr(2'b01, 1'b0, 1'b0, 5'd8, 32'h1234, 32'h0, 32'h0);
    at_neg();
    chk("lit_wb_en", {31'h0, WBWriteEnable}, 32'h1);
    chk("lit_wb_addr", {27'h0, WBWriteAddress}, 32'd8);
    next(); idle(); ReadRegister1 = 5'd8;
    at_neg();
    chk("lit_r8", ReadData1, 32'h1234);

    // Load into R9, seed R5, then link.
    next(); wr(2'b01, 1'b1, 1'b0, 5'd9, 32'h1, 32'h2, 32'hDEADBEEF);
    next(); wr(2'b01, 1'b0, 1'b0, 5'd5, 32'h55, 32'h0, 32'h0);
    next(); wr(2'b00, 1'b0, 1'b1, 5'd5, 32'h99, 32'h48, 32'h77);
    at_neg();
    chk("lit_jal_addr", {27'h0, WBWriteAddress}, 32'd31);
    chk("lit_jal_data", WBWriteData, 32'h48);
    next(); idle(); ReadRegister1 = 5'd31; ReadRegister2 = 5'd5;
    at_neg();
    chk("lit_r31", ReadData1, 32'h48);
    chk("lit_r5", ReadData2, 32'h55);
    ReadRegister1 = 5'd9; #1;
    chk("lit_r9", ReadData1, 32'hDEADBEEF);

    // R0 is never written.
    next(); wr(2'b01, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
    ReadRegister1 = 5'd0;
    at_neg();
    chk("lit_r0_en", {31'h0, WBWriteEnable}, 32'h0);
    chk("lit_r0_rd", ReadData1, 32'h0);
    next(); idle();
    at_neg();
    chk("lit_r0_after", ReadData1, 32'h0);

    // Same-cycle bypass on both ports.
    next(); wr(2'b01, 1'b0, 1'b0, 5'd10, 32'hA5A5A5A5, 32'h0, 32'h0);
    ReadRegister1 = 5'd10; ReadRegister2 = 5'd10;
    at_neg();
    chk("lit_byp1", ReadData1, 32'hA5A5A5A5);
    chk("lit_byp2", ReadData2, 32'hA5A5A5A5);

    // Reserved codes, then reset during a write.
    next(); wr(2'b01, 1'b0, 1'b0, 5'd12, 32'h77, 32'h0, 32'h0);
    next(); wr(2'b10, 1'b0, 1'b0, 5'd12, 32'hBAD, 32'h0, 32'h0);
    next(); wr(2'b11, 1'b0, 1'b0, 5'd12, 32'hBAD, 32'h0, 32'h0);
    next(); idle(); ReadRegister1 = 5'd12; ReadRegister2 = 5'd8;
    at_neg();
    chk("lit_r12_rsvd", ReadData1, 32'h77);
    next(); reset = 1'b1; wr(2'b01, 1'b0, 1'b0, 5'd12, 32'h99, 32'h0, 32'h0);
    next(); reset = 1'b0; idle();
    at_neg();
    chk("lit_r12_rst", ReadData1, 32'h0);
    chk("lit_r8_rst", ReadData2, 32'h0);

    // Random traffic; addresses biased to a small set so bypass and overwrite happen often.
    for (int n = 0; n < 600; n++) begin
      next();
      reset = ($urandom_range(0, 39) == 0);
      RegWrite = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
      MemToReg = 1'($urandom_range(0, 1));
      Jal = ($urandom_range(0, 9) == 0);
      RegWriteAddress = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ALUResult = $urandom; PCAdderOut = $urandom; MemReadData = $urandom;
      ReadRegister1 = ($urandom_range(0, 1) != 0) ? RegWriteAddress : 5'($urandom);
      ReadRegister2 = ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom);
    end
    next();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
